// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register word indices,
// STATUS/CTRL bit positions and the TX sequencer state encoding.
package uart_mmio_pkg;

  // Word index inside the peripheral window (byte offset bits [3:2])
  localparam logic [1:0] W_TXDATA = 2'd0;
  localparam logic [1:0] W_STATUS = 2'd1;
  localparam logic [1:0] W_RXDATA = 2'd2;
  localparam logic [1:0] W_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NE      = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVF     = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CT_RX_IRQ_EN  = 0;
  localparam int CT_TX_IRQ_EN  = 1;
  localparam int CT_CLR_RX_OVF = 8;
  localparam int CT_CLR_TX_OVF = 9;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// Synchronous byte FIFO. A pop on an empty FIFO is ignored; a push while full
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo_8 #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array: data only, no reset needed (guarded by count)
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, a TX start/busy sequencer,
// STATUS/CTRL registers and a registered level interrupt.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [7:0]    tx_byte_q;
  logic [1:0]    ctrl_q;
  logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic          irq_q;

  logic          addr_hit;
  logic [1:0]    word;
  logic          wr, rd;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_idle;
  logic          ctrl_wr;
  logic          unused_wdata;

  // Upper offset bits beyond the 16-byte window make the access unmapped
  assign addr_hit = ((bus_addr >> 4) == '0);
  assign word     = bus_addr[3:2];
  assign wr       = bus_sel && bus_we && addr_hit;
  assign rd       = bus_sel && bus_re && addr_hit;
  assign tx_push  = wr && (word == W_TXDATA);
  assign ctrl_wr  = wr && (word == W_CTRL);
  assign rx_pop   = rd && (word == W_RXDATA) && !rx_empty;
  assign tx_idle  = tx_empty && (state_q == TX_IDLE);

  assign unused_wdata = ^{bus_wdata[DATA_W-1:10], tx_count};

  sync_fifo_8 #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (bus_wdata[7:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  sync_fifo_8 #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_valid),
    .din_i   (rx_byte),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // TX sequencer next state: one byte per start/busy handshake
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START:     state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (tx_busy)  state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (ctrl_wr && bus_wdata[CT_CLR_RX_OVF]) rx_ovf_d = 1'b0;
    if (ctrl_wr && bus_wdata[CT_CLR_TX_OVF]) tx_ovf_d = 1'b0;
    if (rx_valid && rx_full && !rx_pop)      rx_ovf_d = 1'b1;
    if (tx_push && tx_full && !tx_pop)       tx_ovf_d = 1'b1;
  end

  // Sequencer state, latched TX byte, CTRL, flags and registered irq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      tx_byte_q <= 8'h00;
      ctrl_q    <= 2'b00;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      if (tx_pop)  tx_byte_q <= tx_head;
      if (ctrl_wr) ctrl_q    <= bus_wdata[1:0];
      irq_q <= (ctrl_q[CT_RX_IRQ_EN] && !rx_empty) ||
               (ctrl_q[CT_TX_IRQ_EN] && tx_idle)   ||
               rx_ovf_q || tx_ovf_q;
    end
  end

  assign tx_start = (state_q == TX_START);
  assign tx_byte  = tx_byte_q;
  assign irq      = irq_q;

  // Combinational read mux; unmapped and write-only words read 0
  always_comb begin
    bus_rdata = '0;
    if (rd) begin
      case (word)
        W_STATUS: begin
          bus_rdata[ST_RX_NE]            = !rx_empty;
          bus_rdata[ST_TX_FULL]          = tx_full;
          bus_rdata[ST_TX_IDLE]          = tx_idle;
          bus_rdata[ST_RX_OVF]           = rx_ovf_q;
          bus_rdata[ST_TX_OVF]           = tx_ovf_q;
          bus_rdata[ST_RX_CNT_LSB +: CW] = rx_count;
        end
        W_RXDATA: if (!rx_empty) bus_rdata[7:0] = rx_head;
        W_CTRL:   bus_rdata[1:0] = ctrl_q;
        default:  bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with a small uart_tx busy model.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_sel = 1'b0, bus_we = 1'b0, bus_re = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        irq;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int bcnt = 0;
  bit pend = 1'b0;
  int st_cyc[$];
  logic [7:0] st_byte[$];
  int fall_cyc[$];

  uart_mmio_ctrl #(.FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy rises the cycle after a start and stays high 10 cycles
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (pend) begin
      tx_busy = 1'b1;
      bcnt = 10;
      pend = 1'b0;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        tx_busy = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
    if (tx_start) begin
      pend = 1'b1;
      st_cyc.push_back(cyc);
      st_byte.push_back(tx_byte);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_re = 1'b1; bus_addr = a;
    #1;
    d = bus_rdata;
    @(posedge clk); #1;
    bus_sel = 1'b0; bus_re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #3;
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got start=%b byte=%h irq=%b, want 0 00 0", tx_start, tx_byte, irq);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      failures++;
      $display("FAIL reset_status: got %h want 00000004", d);
    end
  endtask

  task automatic test_rx_capture();
    logic [31:0] d;
    logic [7:0] exp[3];
    exp[0] = 8'h05; exp[1] = 8'h03; exp[2] = 8'h0C;
    for (int i = 0; i < 3; i++) rx_push(exp[i]);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0305) begin
      failures++;
      $display("FAIL rx_status3: got %h want 00000305", d);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(4'h8, d);
      checks++;
      if (d !== {24'h0, exp[i]}) begin
        failures++;
        $display("FAIL rx_read%0d: got %h want %h", i, d, {24'h0, exp[i]});
      end
    end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rx_read_empty: got %h want 00000000", d);
    end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      failures++;
      $display("FAIL rx_status_empty: got %h want 00000004", d);
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_040D) begin
      failures++;
      $display("FAIL ovf_status: got %h want 0000040d", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL ovf_irq: got %b want 1", irq);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'h8, d);
      checks++;
      if (d !== 32'h10 + 32'(i)) begin
        failures++;
        $display("FAIL ovf_read%0d: got %h want %h", i, d, 32'h10 + 32'(i));
      end
    end
    bus_write(4'hC, 32'h100);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL ovf_irq_lag: got %b want 1", irq);
    end
    step(1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL ovf_irq_clear: got %b want 0", irq);
    end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      failures++;
      $display("FAIL ovf_status_clear: got %h want 00000004", d);
    end
  endtask

  task automatic test_full_concurrency();
    logic [31:0] d;
    logic [7:0] exp[4];
    exp[0] = 8'h21; exp[1] = 8'h22; exp[2] = 8'h23; exp[3] = 8'h99;
    for (int i = 0; i < 4; i++) rx_push(8'h20 + 8'(i));
    rx_valid = 1'b1; rx_byte = 8'h99;
    bus_sel = 1'b1; bus_re = 1'b1; bus_addr = 4'h8;
    #1;
    d = bus_rdata;
    @(posedge clk); #1;
    rx_valid = 1'b0; bus_sel = 1'b0; bus_re = 1'b0;
    checks++;
    if (d !== 32'h20) begin
      failures++;
      $display("FAIL full_pushpop_read: got %h want 00000020", d);
    end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0405) begin
      failures++;
      $display("FAIL full_pushpop_status: got %h want 00000405", d);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'h8, d);
      checks++;
      if (d !== {24'h0, exp[i]}) begin
        failures++;
        $display("FAIL full_drain%0d: got %h want %h", i, d, {24'h0, exp[i]});
      end
    end
  endtask

  task automatic test_tx_sequencing();
    logic [31:0] d;
    int sb, fb;
    sb = st_cyc.size();
    fb = fall_cyc.size();
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    step(40);
    checks++;
    if (st_cyc.size() - sb !== 2) begin
      failures++;
      $display("FAIL tx_start_count: got %0d want 2", st_cyc.size() - sb);
    end else begin
      checks++;
      if (st_byte[sb] !== 8'h41 || st_byte[sb+1] !== 8'h42) begin
        failures++;
        $display("FAIL tx_bytes: got %h %h want 41 42", st_byte[sb], st_byte[sb+1]);
      end
      checks++;
      if (fall_cyc.size() <= fb) begin
        failures++;
        $display("FAIL tx_gap: got no busy fall want one");
      end else if (st_cyc[sb+1] - fall_cyc[fb] !== 2) begin
        failures++;
        $display("FAIL tx_gap: got %0d want 2", st_cyc[sb+1] - fall_cyc[fb]);
      end
    end
    bus_read(4'h4, d);
    checks++;
    if (d[2] !== 1'b1) begin
      failures++;
      $display("FAIL tx_idle_end: got %b want 1", d[2]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int sb;
    bus_write(4'h0, 32'h61);
    bus_write(4'h0, 32'h62);
    bus_write(4'h0, 32'h63);
    step(3);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset_out: got start=%b byte=%h want 0 00", tx_start, tx_byte);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1);
    sb = st_cyc.size();
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      failures++;
      $display("FAIL midframe_status: got %h want 00000004", d);
    end
    step(15);
    checks++;
    if (st_cyc.size() !== sb) begin
      failures++;
      $display("FAIL midframe_no_start: got %0d starts want 0", st_cyc.size() - sb);
    end
    bus_write(4'h0, 32'h55);
    step(20);
    checks++;
    if (st_cyc.size() - sb !== 1) begin
      failures++;
      $display("FAIL post_reset_tx: got %0d starts want 1", st_cyc.size() - sb);
    end else if (st_byte[sb] !== 8'h55) begin
      failures++;
      $display("FAIL post_reset_tx: got byte %h want 55", st_byte[sb]);
    end
  endtask

  task automatic test_irq_enable();
    logic [31:0] d;
    bus_write(4'hC, 32'h301);
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL ctrl_readback: got %h want 00000001", d);
    end
    rx_push(8'hAA);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_lag_rise: got %b want 0", irq);
    end
    step(1);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'hAA || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_read: got data=%h irq=%b want 000000aa 1", d, irq);
    end
    step(1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: got %b want 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_rx_capture();
    test_rx_overflow();
    test_full_concurrency();
    test_tx_sequencing();
    test_reset_midframe();
    test_irq_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
